// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding, mode constants and defaults for the VC arbiter
package arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   localparam int ARB_DEF_N        = 8;
   localparam int ARB_DEF_MAX_HOLD = 16;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner search over req & ~mask
// Round-robin rotates a doubled vector by the pointer; fixed priority takes the highest index.
module arb_pick
   import arb_pkg::*;
#(
   parameter int N    = ARB_DEF_N,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [N-1:0]    mask_i,
   input  logic [ID_W-1:0] ptr_i,
   input  logic            mode_i,
   output logic [N-1:0]    win_o,
   output logic [ID_W-1:0] win_id_o,
   output logic            any_o
);

   logic [N-1:0] elig;
   logic [N-1:0] rot;
   int           off;
   int           idx;

   always_comb begin
      elig = req_i & ~mask_i;
      rot  = N'({elig, elig} >> ptr_i);
      off  = 0;
      idx  = 0;
      if (mode_i == MODE_RR) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
         end
         idx = int'(ptr_i) + off;
         if (idx >= N) idx = idx - N;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (elig[i]) idx = i;
         end
      end
   end

   assign any_o    = |elig;
   assign win_id_o = any_o ? ID_W'(idx) : '0;
   assign win_o    = any_o ? (N'(1) << win_id_o) : '0;

endmodule

// File: rtl/vc_rr_arbiter.sv
// rtl/vc_rr_arbiter.sv - N-channel VC arbiter: held registered grant, RR or fixed priority
// ARB_TIMEOUT_EN adds a MAX_HOLD cycle forced release with a one-cycle timeout pulse.
module vc_rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = ARB_DEF_N,
   parameter int ID_W     = $clog2(N),
   parameter int MAX_HOLD = ARB_DEF_MAX_HOLD
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [N-1:0]    req,
   input  logic            done,
   input  logic            mode,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            gnt_valid,
   output logic            timeout
);

   arb_state_e      state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [N-1:0]    mask;
   logic [N-1:0]    win;
   logic [ID_W-1:0] win_id;
   logic            win_any;
   logic            owner_req;
   logic            hold_hit;
   logic            rel;

   assign owner_req = |(req & gnt_q);
   assign rel       = (state_q == ARB_GRANT) && (done || !owner_req || hold_hit);
   // The releasing owner sits out the arbitration that replaces it.
   assign mask      = (state_q == ARB_GRANT) ? gnt_q : '0;

   arb_pick #(.N(N), .ID_W(ID_W)) u_pick (
      .req_i    (req),
      .mask_i   (mask),
      .ptr_i    (ptr_q),
      .mode_i   (mode),
      .win_o    (win),
      .win_id_o (win_id),
      .any_o    (win_any)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      if (state_q == ARB_IDLE || rel) begin
         if (win_any) begin
            state_d = ARB_GRANT;
            gnt_d   = win;
            id_d    = win_id;
            if (mode == MODE_RR) begin
               ptr_d = (win_id == ID_W'(N - 1)) ? '0 : win_id + ID_W'(1);
            end
         end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            id_d    = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timeout_q, timeout_d;

   assign hold_hit = (hold_q == HOLD_W'(MAX_HOLD - 1));

   always_comb begin
      hold_d = '0;
      if (state_q == ARB_GRANT && !rel) hold_d = hold_q + HOLD_W'(1);
      timeout_d = rel && hold_hit && !done && owner_req;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign hold_hit = 1'b0;
   assign timeout  = (MAX_HOLD < 1);
`endif

   assign gnt       = gnt_q;
   assign gnt_id    = id_q;
   assign gnt_valid = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// tb/tb_vc_rr_arbiter.sv - directed vector table plus multi-cycle sequences for vc_rr_arbiter
module tb_vc_rr_arbiter;

   localparam int N        = 8;
   localparam int ID_W     = 3;
   localparam int MAX_HOLD = 4;

   logic            clk = 1'b0;
   logic            clr;
   logic [N-1:0]    req;
   logic            done;
   logic            mode;
   logic [N-1:0]    gnt;
   logic [ID_W-1:0] gnt_id;
   logic            gnt_valid;
   logic            timeout;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       clr;
      logic [7:0] req;
      logic       done;
      logic       mode;
      logic [7:0] gnt;
      logic [2:0] id;
      logic       valid;
      logic       tmo;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   vc_rr_arbiter #(.N(N), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .clr       (clr),
      .req       (req),
      .done      (done),
      .mode      (mode),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   task automatic step(input string name, input logic c, input logic [7:0] r, input logic d,
                       input logic m, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic et);
      @(negedge clk);
      clr  = c;
      req  = r;
      done = d;
      mode = m;
      @(posedge clk);
      #1;
      n_vec++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== {eg, ei, ev, et}) begin
         n_err++;
         $display("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
                  name, gnt, gnt_id, gnt_valid, timeout, eg, ei, ev, et);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clr  = 1'b1;
      req  = '0;
      done = 1'b0;
      mode = 1'b0;

      // clr, req, done, mode -> gnt, id, valid, timeout
      tbl.push_back('{1'b1, 8'hA6, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'hA6, 1'b0, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'hA6, 1'b1, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'hA6, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'hA6, 1'b1, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'hA6, 1'b0, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'hA6, 1'b1, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'hA6, 1'b0, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'hA6, 1'b1, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h4E, 1'b1, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h0E, 1'b0, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h06, 1'b0, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h02, 1'b0, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h0A, 1'b0, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h0A, 1'b1, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h0A, 1'b0, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h0A, 1'b1, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0});
      // pointer is still 2 after fixed-priority grants
      tbl.push_back('{1'b0, 8'h82, 1'b0, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h82, 1'b0, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h82, 1'b1, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0});

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("vec%0d", i), tbl[i].clr, tbl[i].req, tbl[i].done, tbl[i].mode,
              tbl[i].gnt, tbl[i].id, tbl[i].valid, tbl[i].tmo);
      end

      // hold: ch2 owns while ch7 and ch0 toggle (pointer 2 -> 3)
      step("hold_grant", 1'b0, 8'h04, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         logic [7:0] r;
         r = 8'h04 | (i[0] ? 8'h80 : 8'h00) | (i[1] ? 8'h01 : 8'h00);
         step($sformatf("hold%0d", i), 1'b0, r, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
      end
      step("hold_end", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

      // back-to-back handover ch3 -> ch4, then idle
      step("b2b_ch3", 1'b0, 8'h08, 1'b0, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
      step("b2b_ch4", 1'b0, 8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
      step("b2b_idle", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

      // reset mid-grant clears the pointer
      step("rst_ch5", 1'b0, 8'h20, 1'b0, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
      step("rst_mid", 1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      step("rst_ptr0", 1'b0, 8'hFF, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
      step("rst_next", 1'b0, 8'hFF, 1'b1, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);

      // hold limit: ch1 never releases while ch2 waits
      step("tmo_clr", 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      step("tmo_ch1", 1'b0, 8'h06, 1'b0, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < MAX_HOLD - 1; i++) begin
         step($sformatf("tmo_hold%0d", i), 1'b0, 8'h06, 1'b0, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      end
      step("tmo_pulse", 1'b0, 8'h06, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b1);
      step("tmo_after", 1'b0, 8'h06, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
`else
      for (int i = 0; i < 12; i++) begin
         step($sformatf("notmo_hold%0d", i), 1'b0, 8'h06, 1'b0, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vc_rr_arbiter.md
Name: vc_rr_arbiter

Overview:
- Parametrised N-channel virtual-channel arbiter; successor to the fixed 8-bit PCIe request arbiter.
- Accepts one request bit per VC and issues a registered one-hot grant plus encoded VC ID.
- Grant is held until the owner signals completion or drops its request.
- Runtime-selectable round-robin or fixed-priority mode; sits between PCIe VC request sources and the shared link transmit path.

Parameters:
- N, 8, number of request channels (N >= 2).
- ID_W, $clog2(N), width of encoded grant ID.
- MAX_HOLD, 16, max cycles a grant may be held; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- clr  input  1  synchronous active-high reset.
- req  input  N  per-channel request, level-sensitive.
- done  input  1  current owner finished; releases grant.
- mode  input  1  0 = round-robin, 1 = fixed priority (highest index wins).
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  ID_W  encoded index of gnt; 0 when no grant.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clock and reset are fixed: one clock, clk; synchronous, active-high reset, clr.
- Reset: on a clk edge with clr=1, all of the following are zero: gnt, gnt_id, gnt_valid, timeout, RR pointer and hold counter; FSM goes to IDLE.
  - clr overrides all other inputs, including a grant in progress.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req != 0, pick a winner; at the next edge, gnt = winner, gnt_valid = 1, go to GRANT.
  - Latency from req to gnt is 1 cycle.
  - If req == 0, stay in IDLE with outputs 0.
- Arbitration, mode=0 (round-robin): search upward from pointer P, wrapping N-1 -> 0. First set bit wins. On grant to channel i, P = (i+1) mod N.
- Arbitration, mode=1 (fixed priority): highest set index wins. P is unchanged.
- mode is sampled only at arbitration points; changes during GRANT are ignored.
- GRANT, hold: grant is held while req[owner]=1 and done=0. Other req changes do not affect it.
- GRANT, release: release occurs when done=1 or req[owner]=0.
  - The same cycle, re-arbitrate over req with the owner bit masked.
  - If a winner exists, the new gnt appears at the next edge with no idle cycle.
  - Otherwise, at the next edge outputs go to 0 and the FSM returns to IDLE.
- Masking the owner means that in round-robin mode, and in fixed-priority mode, the releasing owner cannot immediately re-win; it is eligible again from the following arbitration.
- done while in IDLE is ignored.
- gnt is always one-hot or zero; gnt_id is consistent with gnt in the same cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter increments each GRANT cycle.
  - When it reaches MAX_HOLD-1 with no release, the grant is forced to release exactly as a normal release (owner masked) and timeout pulses high for 1 cycle, coincident with the edge that applies the release.
  - The counter clears on every new grant and on clr.
- Undefined: no counter; timeout is tied 0; a grant may be held indefinitely.

Decomposition:
- Shared package arb_pkg:
  - FSM state enum (ARB_IDLE, ARB_GRANT).
  - Mode constants MODE_RR=1'b0 and MODE_FIXED=1'b1.
  - Default N and MAX_HOLD constants.
- One combinational sub-module, arb_pick:
  - Inputs: req vector, mask, pointer, mode.
  - Outputs: one-hot winner, encoded index, any-valid.
  - Implemented as a double-width rotate-and-priority search.
- Top level holds the FSM, pointer, output registers and optional timeout counter.

Test Plan:
- Reset and RR order, N=8, mode=0:
  - clr=1 with req=8'b10100110 -> gnt=0, gnt_valid=0.
  - clr=0 -> grants gnt_id=1, 2, 5, 7, then 1 again, pulsing done one cycle per grant, each new grant on the edge after the done edge.
- Fixed priority, mode=1:
  - req=8'b01001110 -> gnt_id=6.
  - req changes to 8'b00001110 -> release; next grant gnt_id=3, then 2, then 1.
- Hold:
  - Owner ch2 keeps req high, done=0 for 20 cycles while req[7] and req[0] toggle -> gnt stays 8'b00000100 throughout.
- Back-to-back and idle return:
  - Owner ch3 drops req in the same cycle req[4] rises -> gnt=8'b00010000 next edge, gnt_valid never low.
  - Then all req=0 -> IDLE, outputs 0.
- Reset mid-grant:
  - clr=1 while gnt_id=5 -> next edge gnt=0, gnt_id=0, gnt_valid=0.
  - After release with req=8'hFF, mode=0 -> gnt_id=0 (pointer reset).
- Timeout, ARB_TIMEOUT_EN defined, MAX_HOLD=4:
  - Owner ch1 holds req, done=0, req[2]=1 -> timeout pulses once, gnt moves to ch2 four cycles after the ch1 grant.
  - Without the macro -> ch1 is held indefinitely and timeout stays 0.
